// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: three-channel LED PWM with linear per-period crossfade.
// A shared prescaler/counter sets the PWM period. Each channel lane holds a
// duty register that moves toward its target only at a period boundary.

// One colour lane: duty ramp toward target plus PWM comparator.
module rgb_pwm_chan #(
  parameter int PWM_BITS  = 8,
  parameter int FADE_STEP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                boundary,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic [PWM_BITS-1:0] target,
  output logic                led,
  output logic                diff_now,
  output logic                diff_nxt
);
  localparam logic [PWM_BITS:0] STEP = (PWM_BITS+1)'(FADE_STEP);

  logic [PWM_BITS-1:0] duty, duty_nxt;
  logic [PWM_BITS:0]   gap_up, gap_dn;

  // Step toward target; gaps are one bit wider so the clamp never wraps.
  always_comb begin
    gap_up   = {1'b0, target} - {1'b0, duty};
    gap_dn   = {1'b0, duty} - {1'b0, target};
    duty_nxt = duty;
    if (duty < target)
      duty_nxt = (gap_up > STEP) ? PWM_BITS'({1'b0, duty} + STEP) : target;
    else if (duty > target)
      duty_nxt = (gap_dn > STEP) ? PWM_BITS'({1'b0, duty} - STEP) : target;
  end

  assign diff_now = (duty != target);
  assign diff_nxt = (duty_nxt != target);

  // Duty only moves at a period boundary so a period is never split.
  always_ff @(posedge clk) begin
    if (rst)           duty <= '0;
    else if (boundary) duty <= duty_nxt;
  end

  // Registered comparator; enable gates the pin one clk later.
  always_ff @(posedge clk) begin
    if (rst) led <= 1'b0;
    else     led <= enable && (pwm_cnt < duty);
  end
endmodule

// Top: shared timebase, three lanes, fade state machine.
module rgb_pwm_driver #(
  parameter int PWM_BITS  = 8,
  parameter int PRESCALE  = 4,
  parameter int FADE_STEP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          colour,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                enable,
  output logic                led_r,
  output logic                led_g,
  output logic                led_b,
  output logic                fading,
  output logic                period_start
);
  localparam int NUM_LANES = 3;
  localparam int PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic {STEADY, FADE} state_t;

  logic [PS_W-1:0]                         ps;
  logic [PWM_BITS-1:0]                     pwm_cnt;
  logic                                    tick, boundary;
  logic [NUM_LANES-1:0][PWM_BITS-1:0]      target;
  logic [NUM_LANES-1:0]                    led, diff_now, diff_nxt;
  state_t                                  state, state_nxt;

  assign tick     = (ps == PS_W'(PRESCALE - 1));
  assign boundary = tick && (pwm_cnt == '1);

  // Prescaler: divides clk down to one counter step per PRESCALE cycles.
  always_ff @(posedge clk) begin
    if (rst)       ps <= '0;
    else if (tick) ps <= '0;
    else           ps <= ps + 1'b1;
  end

  // PWM counter wraps naturally at 2^PWM_BITS.
  always_ff @(posedge clk) begin
    if (rst)       pwm_cnt <= '0;
    else if (tick) pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Period marker shows in the cycle after the boundary, independent of enable.
  always_ff @(posedge clk) begin
    if (rst) period_start <= 1'b0;
    else     period_start <= boundary;
  end

  // Lane g takes colour bit g: lane 2 red, lane 1 green, lane 0 blue.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign target[g] = colour[g] ? brightness : '0;
    rgb_pwm_chan #(.PWM_BITS(PWM_BITS), .FADE_STEP(FADE_STEP)) u_chan (
      .clk      (clk),
      .rst      (rst),
      .boundary (boundary),
      .enable   (enable),
      .pwm_cnt  (pwm_cnt),
      .target   (target[g]),
      .led      (led[g]),
      .diff_now (diff_now[g]),
      .diff_nxt (diff_nxt[g])
    );
  end

  // Fade FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= STEADY;
    else     state <= state_nxt;
  end

  // Enter FADE on any pre-update mismatch; leave once the update lands on target.
  always_comb begin
    state_nxt = state;
    if (boundary) begin
      case (state)
        STEADY:  if (|diff_now)  state_nxt = FADE;
        FADE:    if (~|diff_nxt) state_nxt = STEADY;
        default: state_nxt = STEADY;
      endcase
    end
  end

  assign fading = (state == FADE);
  assign led_r  = led[2];
  assign led_g  = led[1];
  assign led_b  = led[0];
endmodule
